// File: rtl/m3_scheduler_pkg.sv
// m3_scheduler_pkg: shared FSM state encoding and width helper for the m3 detector scheduler.
// Revision 1.0
`default_nettype none

package m3_scheduler_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_CLEAR  = 2'd1,
    ST_RUN    = 2'd2,
    ST_REPORT = 2'd3
  } state_t;

  // Counter width for values 0..n-1, never narrower than one bit.
  function automatic int bits_for(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

`default_nettype wire

// File: rtl/m3_scheduler_rr_arbiter.sv
// m3_scheduler_rr_arbiter: round-robin arbiter, pointer advances only when a grant is taken.
// Revision 1.0
`default_nettype none

module m3_scheduler_rr_arbiter #(
  parameter int N_REQ = 4
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic [N_REQ-1:0]         req,
  input  logic                     advance,
  output logic [N_REQ-1:0]         grant,
  output logic [$clog2(N_REQ)-1:0] id
);

  localparam int IDW = $clog2(N_REQ);

  logic [IDW-1:0] ptr;
  logic           found;

  // ptr holds the index with highest priority this cycle.
  always_comb begin
    grant = '0;
    id    = '0;
    found = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      if (!found && req[(int'(ptr) + i) % N_REQ]) begin
        found = 1'b1;
        grant[(int'(ptr) + i) % N_REQ] = 1'b1;
        id = IDW'((int'(ptr) + i) % N_REQ);
      end
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      ptr <= '0;
    end else if (advance) begin
      ptr <= (id == IDW'(N_REQ - 1)) ? '0 : id + IDW'(1);
    end
  end

endmodule

`default_nettype wire

// File: rtl/m3_scheduler.sv
// m3_scheduler: time-shares one serial bit detector among N_REQ requesters, one tagged result per word.
// Revision 1.0
`default_nettype none

module m3_scheduler #(
  parameter int N_REQ   = 4,
  parameter int WORD_W  = 8,
  parameter int DET_LAT = 1
) (
  input  logic                        CLK,
  input  logic                        RST,
  input  logic [N_REQ-1:0]            req,
  input  logic [N_REQ*WORD_W-1:0]     word_in,
  output logic [N_REQ-1:0]            gnt,
  output logic                        det_rst,
  output logic                        det_en,
  output logic                        det_din,
  input  logic                        det_dout,
  output logic                        res_valid,
  output logic [$clog2(N_REQ)-1:0]    res_id,
  output logic                        res_hit,
  output logic                        res_last,
  output logic [$clog2(WORD_W+1)-1:0] res_cnt
);

  import m3_scheduler_pkg::*;

  localparam int IDW     = $clog2(N_REQ);
  localparam int CW      = $clog2(WORD_W + 1);
  localparam int RUN_LEN = WORD_W + DET_LAT;
  localparam int KW      = bits_for(RUN_LEN);

  localparam logic [KW-1:0] K_LAST    = KW'(RUN_LEN - 1);
  localparam logic [KW-1:0] K_EN_LAST = KW'(WORD_W - 1);
  localparam logic [KW-1:0] K_LAT     = KW'(DET_LAT);

  state_t            state, state_nx;
  logic [KW-1:0]     k, k_nx;
  logic [WORD_W-1:0] shreg, shreg_nx;
  logic [IDW-1:0]    cur_id, cur_id_nx;
  logic              acc_hit, acc_hit_nx;
  logic              acc_last, acc_last_nx;
  logic [CW-1:0]     acc_cnt, acc_cnt_nx;

  logic [N_REQ-1:0]  gnt_nx;
  logic              det_rst_nx, det_en_nx, det_din_nx;
  logic              res_valid_nx, res_hit_nx, res_last_nx;
  logic [IDW-1:0]    res_id_nx;
  logic [CW-1:0]     res_cnt_nx;

  logic [N_REQ-1:0]  arb_grant;
  logic [IDW-1:0]    arb_id;
  logic              arb_advance;
  logic [WORD_W-1:0] sel_word;

  assign arb_advance = (state == ST_IDLE) && (|req);
  assign sel_word    = word_in[arb_id*WORD_W +: WORD_W];

  m3_scheduler_rr_arbiter #(
    .N_REQ (N_REQ)
  ) u_arb (
    .CLK     (CLK),
    .RST     (RST),
    .req     (req),
    .advance (arb_advance),
    .grant   (arb_grant),
    .id      (arb_id)
  );

  // Output registers take their next values here, so each pin is high in the
  // same cycle the FSM is in the state that owns it; results publish one cycle after REPORT.
  always_comb begin
    state_nx     = state;
    k_nx         = k;
    shreg_nx     = shreg;
    cur_id_nx    = cur_id;
    acc_hit_nx   = acc_hit;
    acc_last_nx  = acc_last;
    acc_cnt_nx   = acc_cnt;
    gnt_nx       = '0;
    det_rst_nx   = 1'b0;
    det_en_nx    = 1'b0;
    det_din_nx   = 1'b0;
    res_valid_nx = 1'b0;
    res_id_nx    = res_id;
    res_hit_nx   = res_hit;
    res_last_nx  = res_last;
    res_cnt_nx   = res_cnt;

    case (state)
      ST_IDLE: begin
        if (|req) begin
          state_nx    = ST_CLEAR;
          cur_id_nx   = arb_id;
          shreg_nx    = sel_word;
          gnt_nx      = arb_grant;
          det_rst_nx  = 1'b1;
          acc_hit_nx  = 1'b0;
          acc_last_nx = 1'b0;
          acc_cnt_nx  = '0;
        end
      end
      ST_CLEAR: begin
        state_nx   = ST_RUN;
        k_nx       = '0;
        det_en_nx  = 1'b1;
        det_din_nx = shreg[WORD_W-1];
        shreg_nx   = shreg << 1;
      end
      ST_RUN: begin
        k_nx = k + KW'(1);
        if (k < K_EN_LAST) begin
          det_en_nx  = 1'b1;
          det_din_nx = shreg[WORD_W-1];
          shreg_nx   = shreg << 1;
        end
        if (k >= K_LAT) begin
          acc_hit_nx  = acc_hit | det_dout;
          acc_last_nx = det_dout;
          acc_cnt_nx  = acc_cnt + CW'(det_dout);
        end
        if (k == K_LAST) begin
          state_nx = ST_REPORT;
        end
      end
      ST_REPORT: begin
        state_nx     = ST_IDLE;
        res_valid_nx = 1'b1;
        res_id_nx    = cur_id;
        res_hit_nx   = acc_hit;
        res_last_nx  = acc_last;
        res_cnt_nx   = acc_cnt;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state     <= ST_IDLE;
      k         <= '0;
      shreg     <= '0;
      cur_id    <= '0;
      acc_hit   <= 1'b0;
      acc_last  <= 1'b0;
      acc_cnt   <= '0;
      gnt       <= '0;
      det_rst   <= 1'b1;
      det_en    <= 1'b0;
      det_din   <= 1'b0;
      res_valid <= 1'b0;
      res_id    <= '0;
      res_hit   <= 1'b0;
      res_last  <= 1'b0;
      res_cnt   <= '0;
    end else begin
      state     <= state_nx;
      k         <= k_nx;
      shreg     <= shreg_nx;
      cur_id    <= cur_id_nx;
      acc_hit   <= acc_hit_nx;
      acc_last  <= acc_last_nx;
      acc_cnt   <= acc_cnt_nx;
      gnt       <= gnt_nx;
      det_rst   <= det_rst_nx;
      det_en    <= det_en_nx;
      det_din   <= det_din_nx;
      res_valid <= res_valid_nx;
      res_id    <= res_id_nx;
      res_hit   <= res_hit_nx;
      res_last  <= res_last_nx;
      res_cnt   <= res_cnt_nx;
    end
  end

endmodule

`default_nettype wire
